clock_set_controller: RTL and testbench

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

---
 rtl/clock_set_controller.sv | 197 +++++++++++++++++++
 tb/tb_clock_set_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// clock_set_controller: MODE/INC button sequencing for setting a clock's hours and minutes.
// MODE walks RUN -> SET_HOURS -> SET_MINUTES -> RUN; INC requests an increment of the field
// being edited; the edited field blinks, and an idle timeout falls back to RUN.
// Optional feature: define CLOCK_SET_AUTO_REPEAT_EN to build auto-repeat on a held INC button.
module clock_set_controller #(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 10_000_000,
    parameter int unsigned BLINK_CYCLES   = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_pressed_pulse,
    input  logic       inc_pressed_status,
    input  logic       inc_pressed_pulse,
    output logic [1:0] set_mode,
    output logic       inc_hours_pulse,
    output logic       inc_minutes_pulse,
    output logic       clear_seconds_pulse,
    output logic       blink
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN         = 2'b00,
        ST_SET_HOURS   = 2'b01,
        ST_SET_MINUTES = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_set_c;
    logic             timeout_c;
    logic             state_change_c;
    logic             inc_repeat_c;
    logic             inc_req_c;
    logic             inc_hours_d;
    logic             inc_minutes_d;
    logic             clear_seconds_d;
    logic             blink_d;
    logic [CNT_W-1:0] blink_cnt_q;
    logic [CNT_W-1:0] blink_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_d;

    // Set-state qualifier and idle-timeout detection (any input activity counts as not idle)
    assign in_set_c  = (state_q != ST_RUN);
    assign timeout_c = in_set_c && !mode_pressed_pulse && !inc_pressed_pulse &&
                       !inc_pressed_status && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: MODE steps the sequence and takes priority over the idle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mode_pressed_pulse) state_d = ST_SET_HOURS;
            end
            ST_SET_HOURS: begin
                if (mode_pressed_pulse) state_d = ST_SET_MINUTES;
                else if (timeout_c)     state_d = ST_RUN;
            end
            ST_SET_MINUTES: begin
                if (mode_pressed_pulse) state_d = ST_RUN;
                else if (timeout_c)     state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign state_change_c = (state_d != state_q);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_inc_c;
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] rep_cnt_inc_c;
    logic             past_hold_c;
    logic             rep_wrap_c;
    logic             armed_q;

    // Next values of the saturating hold counter and the repeat interval counter
    assign hold_cnt_inc_c = (hold_cnt_q == CNT_MAX) ? CNT_MAX : hold_cnt_q + CNT_W'(1);
    assign rep_cnt_inc_c  = rep_cnt_q + CNT_W'(1);
    assign past_hold_c    = (hold_cnt_inc_c > CNT_W'(HOLD_CYCLES));
    assign rep_wrap_c     = (rep_cnt_inc_c == CNT_W'(REPEAT_CYCLES));

    // Extra increment after HOLD cycles of continuous hold, then every REPEAT cycles
    assign inc_repeat_c = armed_q && inc_pressed_status && !inc_pressed_pulse &&
                          !mode_pressed_pulse &&
                          ((hold_cnt_inc_c == CNT_W'(HOLD_CYCLES)) || (past_hold_c && rep_wrap_c));

    // Hold/repeat counters; arming needs a fresh press inside the current set state
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            if (mode_pressed_pulse || inc_pressed_pulse || !inc_pressed_status) begin
                hold_cnt_q <= '0;
            end else begin
                hold_cnt_q <= hold_cnt_inc_c;
            end

            if (mode_pressed_pulse || inc_pressed_pulse || !inc_pressed_status ||
                !past_hold_c || rep_wrap_c) begin
                rep_cnt_q <= '0;
            end else begin
                rep_cnt_q <= rep_cnt_inc_c;
            end

            if (state_change_c || !inc_pressed_status) begin
                armed_q <= 1'b0;
            end else if (inc_pressed_pulse && in_set_c) begin
                armed_q <= 1'b1;
            end
        end
    end
`else
    // Single increment per press; hold timing parameters have no effect in this build
    assign inc_repeat_c = 1'b0;

    if ((HOLD_CYCLES == 0) || (REPEAT_CYCLES == 0)) begin : g_repeat_timing_unused
    end
`endif

    // INC is honoured only in set states and is discarded when MODE arrives in the same cycle
    assign inc_req_c = in_set_c && !mode_pressed_pulse && (inc_pressed_pulse || inc_repeat_c);

    // Output and counter next values
    always_comb begin
        inc_hours_d     = 1'b0;
        inc_minutes_d   = 1'b0;
        clear_seconds_d = 1'b0;
        blink_d         = blink;
        blink_cnt_d     = blink_cnt_q;
        idle_cnt_d      = idle_cnt_q + CNT_W'(1);

        if (inc_req_c) begin
            if (state_q == ST_SET_HOURS) inc_hours_d   = 1'b1;
            else                         inc_minutes_d = 1'b1;
        end

        if (mode_pressed_pulse && (state_q == ST_SET_MINUTES)) begin
            clear_seconds_d = 1'b1;
        end

        if (state_change_c || (state_d == ST_RUN)) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == CNT_W'(BLINK_CYCLES - 1)) begin
            blink_d     = ~blink;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end

        if (state_change_c || !in_set_c || mode_pressed_pulse || inc_pressed_pulse ||
            inc_pressed_status) begin
            idle_cnt_d = '0;
        end
    end

    // Registered outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_hours_pulse     <= 1'b0;
            inc_minutes_pulse   <= 1'b0;
            clear_seconds_pulse <= 1'b0;
            blink               <= 1'b1;
            blink_cnt_q         <= '0;
            idle_cnt_q          <= '0;
        end else begin
            inc_hours_pulse     <= inc_hours_d;
            inc_minutes_pulse   <= inc_minutes_d;
            clear_seconds_pulse <= clear_seconds_d;
            blink               <= blink_d;
            blink_cnt_q         <= blink_cnt_d;
            idle_cnt_q          <= idle_cnt_d;
        end
    end

    assign set_mode = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus randomized button activity,
// checked against a cycle-count based reference model.
module tb_clock_set_controller;

    localparam int HOLD    = 8;
    localparam int REPEAT  = 4;
    localparam int BLINK   = 5;
    localparam int TIMEOUT = 64;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       mode_pressed_pulse;
    logic       inc_pressed_status;
    logic       inc_pressed_pulse;
    logic [1:0] set_mode;
    logic       inc_hours_pulse;
    logic       inc_minutes_pulse;
    logic       clear_seconds_pulse;
    logic       blink;

    clock_set_controller #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .BLINK_CYCLES  (BLINK),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mode_pressed_pulse (mode_pressed_pulse),
        .inc_pressed_status (inc_pressed_status),
        .inc_pressed_pulse  (inc_pressed_pulse),
        .set_mode           (set_mode),
        .inc_hours_pulse    (inc_hours_pulse),
        .inc_minutes_pulse  (inc_minutes_pulse),
        .clear_seconds_pulse(clear_seconds_pulse),
        .blink              (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode index, cycle stamps of entry / last activity / last press
    int   cyc = 0;
    int   m_mode = 0;
    bit   m_armed = 1'b0;
    int   last_act = 0;
    int   press_cyc = 0;
    int   entry_cyc = 0;
    bit   model_valid = 1'b0;
    logic [1:0] e_mode = 2'b00;
    logic e_inch = 1'b0;
    logic e_incm = 1'b0;
    logic e_clr = 1'b0;
    logic e_blink = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_now();
        if (model_valid) begin
            chk("set_mode", 32'(set_mode), 32'(e_mode));
            chk("inc_hours_pulse", 32'(inc_hours_pulse), 32'(e_inch));
            chk("inc_minutes_pulse", 32'(inc_minutes_pulse), 32'(e_incm));
            chk("clear_seconds_pulse", 32'(clear_seconds_pulse), 32'(e_clr));
            chk("blink", 32'(blink), 32'(e_blink));
            chk("one_pulse_max",
                32'($countones({inc_hours_pulse, inc_minutes_pulse, clear_seconds_pulse}) <= 1),
                32'd1);
        end
    endtask

    // Check outputs of the current cycle, apply inputs, predict the next cycle, advance
    task automatic step(input bit r, input bit m, input bit s, input bit p);
        int nm;
        int d;
        bit fire;
        check_now();
        rst                = r;
        mode_pressed_pulse = m;
        inc_pressed_status = s;
        inc_pressed_pulse  = p;
        e_inch = 1'b0;
        e_incm = 1'b0;
        e_clr  = 1'b0;
        if (r) begin
            m_mode   = 0;
            m_armed  = 1'b0;
            last_act = cyc;
            e_mode   = 2'b00;
            e_blink  = 1'b1;
        end else begin
            nm = m_mode;
            if (m) begin
                nm    = (m_mode + 1) % 3;
                e_clr = (m_mode == 2);
            end else if (m_mode != 0 && !s && !p && (cyc - last_act) >= TIMEOUT) begin
                nm = 0;
            end else if (m_mode != 0) begin
                fire = p;
                if (AR && m_armed && s && !p) begin
                    d = cyc - press_cyc;
                    if (d >= HOLD && ((d - HOLD) % REPEAT) == 0) fire = 1'b1;
                end
                e_inch = fire && (m_mode == 1);
                e_incm = fire && (m_mode == 2);
            end
            if (m || p || s) last_act = cyc;
            if (p && s && m_mode != 0) begin
                m_armed   = 1'b1;
                press_cyc = cyc;
            end
            if (!s || nm != m_mode) m_armed = 1'b0;
            if (nm != m_mode) entry_cyc = cyc + 1;
            m_mode  = nm;
            e_mode  = 2'(nm);
            e_blink = (nm == 0) ? 1'b1 : ((((cyc + 1 - entry_cyc) / BLINK) % 2) == 0);
        end
        model_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int  hold_left;
        int  gap_left;
        int  mode_div;
        bit  rs;
        bit  ms;
        bit  ss;
        bit  ps;

        rst = 1'b1;
        mode_pressed_pulse = 1'b0;
        inc_pressed_status = 1'b0;
        inc_pressed_pulse  = 1'b0;
        @(posedge clk);
        #1;

        // MODE sequencing and clear-seconds on SET_MINUTES -> RUN
        step(1, 0, 0, 0);
        for (int t = 0; t < 23; t++) begin
            if (t == 0)  chk("reset_mode", 32'(set_mode), 32'd0);
            if (t == 0)  chk("reset_blink", 32'(blink), 32'd1);
            if (t == 3)  chk("seq_hours", 32'(set_mode), 32'd1);
            if (t == 11) chk("seq_minutes", 32'(set_mode), 32'd2);
            if (t == 21) chk("seq_run", 32'(set_mode), 32'd0);
            chk("seq_clear", 32'(clear_seconds_pulse), 32'(t == 21));
            step(0, (t == 2 || t == 10 || t == 20), 0, 0);
        end

        // Held INC in SET_HOURS
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int t = 0; t < 25; t++) begin
            chk("hold_hours",
                32'(inc_hours_pulse),
                32'(AR ? (t == 1 || t == 9 || t == 13 || t == 17) : (t == 1)));
            chk("hold_minutes", 32'(inc_minutes_pulse), 32'd0);
            step(0, 0, (t <= 19), (t == 0));
        end

        // MODE and INC coincide in SET_MINUTES
        step(1, 0, 0, 0);
        for (int t = 0; t < 9; t++) begin
            if (t == 6) begin
                chk("coinc_mode", 32'(set_mode), 32'd0);
                chk("coinc_clear", 32'(clear_seconds_pulse), 32'd1);
                chk("coinc_inc_min", 32'(inc_minutes_pulse), 32'd0);
            end
            step(0, (t == 0 || t == 1 || t == 5), (t == 5), (t == 5));
        end

        // INC ignored in RUN
        step(1, 0, 0, 0);
        for (int t = 0; t < 32; t++) begin
            chk("run_inc", 32'({inc_hours_pulse, inc_minutes_pulse}), 32'd0);
            chk("run_blink", 32'(blink), 32'd1);
            step(0, 0, (t < 30), (t == 0));
        end

        // Blink and idle timeout in SET_HOURS
        step(1, 0, 0, 0);
        for (int t = 0; t < 71; t++) begin
            chk("idle_clear", 32'(clear_seconds_pulse), 32'd0);
            if (t >= 3 && t <= 66) begin
                chk("idle_mode", 32'(set_mode), 32'd1);
                chk("idle_blink", 32'(blink), 32'((((t - 3) / 5) % 2) == 0));
            end
            if (t >= 67) begin
                chk("timeout_mode", 32'(set_mode), 32'd0);
                chk("timeout_blink", 32'(blink), 32'd1);
            end
            step(0, (t == 2), 0, 0);
        end

        // Reset during a held INC, then immediate MODE after reset
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int t = 0; t < 14; t++) begin
            if (t == 11) begin
                chk("rst_mode", 32'(set_mode), 32'd0);
                chk("rst_pulses",
                    32'({inc_hours_pulse, inc_minutes_pulse, clear_seconds_pulse}), 32'd0);
                chk("rst_blink", 32'(blink), 32'd1);
            end
            if (t == 12) chk("post_rst_mode", 32'(set_mode), 32'd1);
            step((t == 10), (t == 11), 1, (t == 0));
        end

        // Randomized button activity
        step(1, 0, 0, 0);
        hold_left = 0;
        gap_left  = 3;
        for (int i = 0; i < 3000; i++) begin
            mode_div = (i < 1500) ? 30 : 150;
            rs = ($urandom_range(0, 599) == 0);
            ms = ($urandom_range(0, mode_div - 1) == 0);
            ps = 1'b0;
            if (hold_left > 0) begin
                ss = 1'b1;
                hold_left--;
            end else if (gap_left > 0) begin
                ss = 1'b0;
                gap_left--;
            end else begin
                ss = 1'b1;
                ps = 1'b1;
                hold_left = $urandom_range(0, 24);
                gap_left  = $urandom_range(1, 90);
            end
            step(rs, ms, ss, ps);
        end
        check_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
